// File: rtl/bus_arbiter_if.sv
// Bundle of the two master ports, the shared slave port and the grant vector.
// slave: the arbiter's view (serves the masters); master: the environment's view.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [3:0]        m0_wmask;
  logic              m0_rstrb;
  logic [31:0]       m0_rdata;
  logic              m0_ack;

  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [3:0]        m1_wmask;
  logic              m1_rstrb;
  logic [31:0]       m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wmask;
  logic              s_rstrb;
  logic [31:0]       s_rdata;

  logic [1:0]        grant;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  s_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output s_addr, s_wdata, s_wmask, s_rstrb,
    output grant
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output s_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  s_addr, s_wdata, s_wmask, s_rstrb,
    input  grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with fixed slave read latency.
// All outputs are registered; next-state and next-output logic share one always_comb.
module bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input logic          clk,
  input logic          resetn,
  bus_arbiter_if.slave bus
);

  localparam int unsigned CntW = 2;

  typedef enum logic [1:0] {StIdle, StIssue, StRwait, StAck} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              write_q, write_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wmask_q, s_wmask_d;
  logic              s_rstrb_q, s_rstrb_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;

  logic req0, req1, busy;

  assign req0 = bus.m0_rstrb | (|bus.m0_wmask);
  assign req1 = bus.m1_rstrb | (|bus.m1_wmask);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    s_wmask_d  = '0;
    s_rstrb_d  = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the master that was not served last wins.
          owner_d   = (req0 && req1) ? ~last_q : req1;
          write_d   = owner_d ? (|bus.m1_wmask) : (|bus.m0_wmask);
          s_wmask_d = owner_d ? bus.m1_wmask : bus.m0_wmask;
          s_rstrb_d = ~write_d;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (write_q) begin
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = StAck;
        end else begin
          cnt_d   = CntW'(RD_LAT - 1);
          state_d = StRwait;
        end
      end
      StRwait: begin
        if (cnt_q == '0) begin
          if (owner_q) m1_rdata_d = bus.s_rdata;
          else         m0_rdata_d = bus.s_rdata;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy      = (state_d != StIdle);
    grant_d   = busy ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    s_addr_d  = busy ? (owner_d ? bus.m1_addr : bus.m0_addr) : '0;
    s_wdata_d = busy ? (owner_d ? bus.m1_wdata : bus.m0_wdata) : '0;
  end

  // last_q resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wmask_q  <= '0;
      s_rstrb_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wmask_q  <= s_wmask_d;
      s_rstrb_q  <= s_rstrb_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wmask  = s_wmask_q;
  assign bus.s_rstrb  = s_rstrb_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;

endmodule
